// File: rtl/mul_pkg.sv
// Shared types and elaboration helpers for the pipelined Wallace multiplier and future MAC.
// The constants describe the default 32-bit build; width-generic sizing uses the functions below.
package mul_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_TAG_W = 5;
   localparam int PROD_W    = 2 * DEF_WIDTH;
   localparam int PP_CNT    = DEF_WIDTH + 1;

   typedef struct packed {
      logic                 vld;
      logic                 sgn;
      logic [DEF_TAG_W-1:0] tag;
      logic [PROD_W-1:0]    sum;
      logic [PROD_W-1:0]    cry;
   } stage_t;

   function automatic int prod_w(input int w);
      return 2 * w;
   endfunction

   function automatic int pp_cnt(input int w);
      return w + 1;
   endfunction

   // Each 3:2 level turns every full group of three rows into two and passes leftovers through.
   function automatic int csa_next(input int n);
      return (n / 3) * 2 + (n % 3);
   endfunction

   function automatic int csa_rows(input int n, input int lvl);
      int r;
      r = n;
      for (int i = 0; i < lvl; i++)
         if (r > 2) r = csa_next(r);
      return r;
   endfunction

   function automatic int csa_levels(input int n);
      int r;
      int l;
      r = n;
      l = 0;
      while (r > 2) begin
         r = csa_next(r);
         l++;
      end
      return l;
   endfunction

endpackage

// File: rtl/wallace_csa_tree.sv
// Combinational Wallace reduction: two (WIDTH+1)-bit extended operands to sum/carry rows, zero latency.
// No handshake; the sum of both rows modulo 2^(2*WIDTH) is the product.
module wallace_csa_tree
   import mul_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
)(
   input  logic [WIDTH:0]       i_a_ext,
   input  logic [WIDTH:0]       i_b_ext,
   output logic [2*WIDTH-1:0]   o_sum,
   output logic [2*WIDTH-1:0]   o_cry
);

   localparam int PW   = prod_w(WIDTH);
   localparam int NPP  = pp_cnt(WIDTH);
   localparam int LVLS = csa_levels(NPP);

   logic [PW-1:0] w_a_sx;
   logic [PW-1:0] w_pp [NPP];

   assign w_a_sx = {{(PW-WIDTH-1){i_a_ext[WIDTH]}}, i_a_ext};

   for (genvar i = 0; i < WIDTH; i++) begin : g_pp
      assign w_pp[i] = i_b_ext[i] ? (w_a_sx << i) : '0;
   end
   // The multiplier's top bit carries negative weight, so its row is the negated shifted multiplicand.
   assign w_pp[WIDTH] = i_b_ext[WIDTH] ? (~(w_a_sx << WIDTH) + PW'(1)) : '0;

   for (genvar l = 0; l < LVLS; l++) begin : g_lvl
      localparam int NI = csa_rows(NPP, l);
      localparam int NO = csa_rows(NPP, l + 1);
      localparam int NG = NI / 3;

      logic [PW-1:0] w_in  [NI];
      logic [PW-1:0] w_out [NO];

      if (l == 0) begin : g_src
         for (genvar j = 0; j < NI; j++) begin : g_cp
            assign w_in[j] = w_pp[j];
         end
      end else begin : g_src
         for (genvar j = 0; j < NI; j++) begin : g_cp
            assign w_in[j] = g_lvl[l-1].w_out[j];
         end
      end

      for (genvar j = 0; j < NO; j++) begin : g_out
         if (j < 2 * NG && j % 2 == 0) begin : g_row
            assign w_out[j] = w_in[3*(j/2)] ^ w_in[3*(j/2)+1] ^ w_in[3*(j/2)+2];
         end else if (j < 2 * NG) begin : g_row
            assign w_out[j] = ((w_in[3*(j/2)]   & w_in[3*(j/2)+1]) |
                               (w_in[3*(j/2)]   & w_in[3*(j/2)+2]) |
                               (w_in[3*(j/2)+1] & w_in[3*(j/2)+2])) << 1;
         end else begin : g_row
            assign w_out[j] = w_in[3*NG + j - 2*NG];
         end
      end
   end

   assign o_sum = g_lvl[LVLS-1].w_out[0];
   assign o_cry = g_lvl[LVLS-1].w_out[1];

endmodule

// File: rtl/wallace_mul_pipe.sv
// Tagged pipelined multiplier: STAGES-cycle latency, 1 op/cycle; whole pipe stalls when the result is not taken.
// Define WALLACE_MUL_FLUSH_EN to add a flush input that squashes every in-flight op.
module wallace_mul_pipe
   import mul_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STAGES = 3,
   parameter int TAG_W  = DEF_TAG_W
)(
   input  logic               clk,
   input  logic               rst_n,
`ifdef WALLACE_MUL_FLUSH_EN
   input  logic               flush,
`endif
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_signed,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_prod,
   output logic [TAG_W-1:0]   out_tag,
   output logic               busy
);

   localparam int PW   = prod_w(WIDTH);
   localparam int NREG = STAGES - 1;

   typedef struct packed {
      logic             vld;
      logic [TAG_W-1:0] tag;
      logic [PW-1:0]    sum;
      logic [PW-1:0]    cry;
   } pl_t;

   logic             w_adv;
   logic             w_flush;
   logic             w_acc;
   logic             w_busy;
   logic [WIDTH:0]   w_a_ext;
   logic [WIDTH:0]   w_b_ext;
   logic [PW-1:0]    w_sum;
   logic [PW-1:0]    w_cry;

   pl_t              r_pl [NREG];
   logic             r_out_vld;
   logic [PW-1:0]    r_out_prod;
   logic [TAG_W-1:0] r_out_tag;

`ifdef WALLACE_MUL_FLUSH_EN
   assign w_flush = flush;
`else
   assign w_flush = 1'b0;
`endif

   assign w_adv    = !r_out_vld || out_ready;
   assign in_ready = w_adv && !w_flush;
   assign w_acc    = in_valid && in_ready;

   assign w_a_ext = {in_signed & in_a[WIDTH-1], in_a};
   assign w_b_ext = {in_signed & in_b[WIDTH-1], in_b};

   wallace_csa_tree #(.WIDTH(WIDTH)) u_tree (
      .i_a_ext (w_a_ext),
      .i_b_ext (w_b_ext),
      .o_sum   (w_sum),
      .o_cry   (w_cry)
   );

   // Stage 1 holds the carry-save rows, middle stages only delay, the output stage resolves the add.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NREG; k++) r_pl[k] <= '0;
         r_out_vld  <= 1'b0;
         r_out_prod <= '0;
         r_out_tag  <= '0;
      end else if (w_flush) begin
         for (int k = 0; k < NREG; k++) r_pl[k].vld <= 1'b0;
         r_out_vld <= 1'b0;
      end else if (w_adv) begin
         r_pl[0].vld <= w_acc;
         r_pl[0].tag <= in_tag;
         r_pl[0].sum <= w_sum;
         r_pl[0].cry <= w_cry;
         for (int k = 1; k < NREG; k++) r_pl[k] <= r_pl[k-1];
         r_out_vld  <= r_pl[NREG-1].vld;
         r_out_prod <= r_pl[NREG-1].sum + r_pl[NREG-1].cry;
         r_out_tag  <= r_pl[NREG-1].tag;
      end
   end

   always_comb begin
      w_busy = r_out_vld;
      for (int k = 0; k < NREG; k++) w_busy = w_busy | r_pl[k].vld;
   end

   assign busy      = w_busy;
   assign out_valid = r_out_vld;
   assign out_prod  = r_out_prod;
   assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_wallace_mul_pipe.sv
// Scoreboard bench for wallace_mul_pipe: driver pushes model results, a monitor pops on each handshake.
module tb_wallace_mul_pipe;

   localparam int W  = 32;
   localparam int ST = 3;
   localparam int TW = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic          in_signed;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic [TW-1:0] in_tag;
   logic          out_valid;
   logic          out_ready;
   logic [2*W-1:0] out_prod;
   logic [TW-1:0] out_tag;
   logic          busy;
`ifdef WALLACE_MUL_FLUSH_EN
   logic          flush;
`endif

   wallace_mul_pipe #(.WIDTH(W), .STAGES(ST), .TAG_W(TW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef WALLACE_MUL_FLUSH_EN
      .flush     (flush),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_signed (in_signed),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_prod  (out_prod),
      .out_tag   (out_tag),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [63:0] prod;
      logic [4:0]  tag;
      int          cyc;
      bit          lat;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   lat_chk = 0;
   bit   rnd_ready = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Reference: extend per signedness, multiply as 64-bit integers, keep the low 64 bits.
   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input bit s);
      longint sa;
      longint sb;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'b0, a});
         sb = longint'({32'b0, b});
      end
      return 64'(sa * sb);
   endfunction

   task automatic send(input logic [31:0] a, input logic [31:0] b, input bit s,
                       input logic [4:0] tag, input logic [63:0] exp);
      bit   acc;
      exp_t e;
      acc = 0;
      in_valid = 1; in_a = a; in_b = b; in_signed = s; in_tag = tag;
      for (int w = 0; w < 60 && !acc; w++) begin
         #1;
         if (in_ready) begin
            e.prod = exp; e.tag = tag; e.cyc = cyc; e.lat = lat_chk;
            q.push_back(e);
            acc = 1;
         end
         @(negedge clk);
      end
      in_valid = 0;
      if (!acc) begin
         n_tests++; n_fail++;
         $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 60 cycles");
      end
   endtask

   task automatic drain();
      for (int w = 0; w < 300 && q.size() != 0; w++) @(negedge clk);
      check("drain_queue_empty", 64'(q.size()), 64'd0);
      repeat (2) @(negedge clk);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(5))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   always @(negedge clk) if (rnd_ready) out_ready = 1'($urandom_range(1));

   // Monitor: handshake rule, stall stability, and in-order result checking.
   initial begin
      logic [63:0] hold_p;
      logic [4:0]  hold_t;
      bit          stalled;
      logic        exp_rdy;
      exp_t        e;
      stalled = 0;
      hold_p = '0;
      hold_t = '0;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n) begin
            exp_rdy = !out_valid || out_ready;
`ifdef WALLACE_MUL_FLUSH_EN
            exp_rdy = exp_rdy && !flush;
`endif
            check("in_ready_rule", 64'(in_ready), 64'(exp_rdy));
            if (stalled && out_valid) begin
               check("stall_prod_stable", out_prod, hold_p);
               check("stall_tag_stable", 64'(out_tag), 64'(hold_t));
            end
            if (out_valid && out_ready) begin
               if (q.size() == 0) begin
                  n_tests++; n_fail++;
                  $display("FAIL unexpected_result: got tag %0d prod %h, expected no result", out_tag, out_prod);
               end else begin
                  e = q.pop_front();
                  check("result_prod", out_prod, e.prod);
                  check("result_tag", 64'(out_tag), 64'(e.tag));
                  if (e.lat) check("latency", 64'(cyc - e.cyc), 64'(ST));
               end
            end
            stalled = out_valid && !out_ready;
            hold_p  = out_prod;
            hold_t  = out_tag;
         end else begin
            stalled = 0;
         end
      end
   end

   initial begin
      logic [31:0] a;
      logic [31:0] b;
      bit          s;
      rst_n = 0; in_valid = 0; in_signed = 0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1;
`ifdef WALLACE_MUL_FLUSH_EN
      flush = 0;
`endif
      repeat (3) @(negedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_out_prod", out_prod, 64'd0);
      check("rst_out_tag", 64'(out_tag), 64'd0);
      @(negedge clk);
      rst_n = 1;
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);

      // Directed arithmetic, back-to-back with latency checks.
      lat_chk = 1;
      send(32'h00e00003, 32'h0000a000, 0, 5'd3, 64'h0000_008C_0001_E000);
      send(32'h0000FFFF, 32'h0000FFFF, 0, 5'd4, 64'h0000_0000_FFFE_0001);
      send(32'hFFFFFFFF, 32'h00000002, 1, 5'd5, 64'hFFFF_FFFF_FFFF_FFFE);
      send(32'hFFFFFFFF, 32'h00000002, 0, 5'd6, 64'h0000_0001_FFFF_FFFE);
      send(32'h80000000, 32'h80000000, 1, 5'd7, 64'h4000_0000_0000_0000);
      drain();
      lat_chk = 0;

      // Backpressure: four ops against a held-off output.
      out_ready = 0;
      fork
         begin
            for (int i = 0; i < 4; i++) begin
               a = $urandom; b = $urandom; s = 1'(i);
               send(a, b, s, 5'(10 + i), model(a, b, s));
            end
         end
         begin
            for (int w = 0; w < 50 && !out_valid; w++) @(negedge clk);
            #1;
            check("bp_out_valid_rose", 64'(out_valid), 64'd1);
            check("bp_in_ready_low", 64'(in_ready), 64'd0);
            check("bp_busy", 64'(busy), 64'd1);
            repeat (5) @(negedge clk);
            out_ready = 1;
         end
      join
      drain();

      // Asynchronous reset with two ops in flight.
      send(32'h1234_5678, 32'h0000_0100, 0, 5'd20, model(32'h1234_5678, 32'h0000_0100, 0));
      send(32'hDEAD_BEEF, 32'h0000_0003, 1, 5'd21, model(32'hDEAD_BEEF, 32'h0000_0003, 1));
      @(posedge clk);
      #3 rst_n = 0;
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      q.delete();
      #4 rst_n = 1;
      repeat (6) @(negedge clk);
      #1;
      check("postrst_busy", 64'(busy), 64'd0);

      // Randomized traffic with random backpressure.
      rnd_ready = 1;
      for (int i = 0; i < 300; i++) begin
         a = pick_operand(); b = pick_operand(); s = 1'($urandom_range(1));
         send(a, b, s, 5'($urandom), model(a, b, s));
         if ($urandom_range(3) == 0) @(negedge clk);
      end
      rnd_ready = 0;
      out_ready = 1;
      drain();

`ifdef WALLACE_MUL_FLUSH_EN
      send(32'h0000_0011, 32'h0000_0022, 0, 5'd1, model(32'h0000_0011, 32'h0000_0022, 0));
      send(32'h0000_0033, 32'h0000_0044, 0, 5'd2, model(32'h0000_0033, 32'h0000_0044, 0));
      flush = 1; in_valid = 1; in_a = 32'd9; in_b = 32'd9; in_signed = 0; in_tag = 5'd30;
      #1;
      check("flush_in_ready", 64'(in_ready), 64'd0);
      check("flush_busy_before", 64'(busy), 64'd1);
      q.delete();
      @(negedge clk);
      flush = 0; in_valid = 0;
      #1;
      check("flush_out_valid", 64'(out_valid), 64'd0);
      check("flush_busy_after", 64'(busy), 64'd0);
      @(negedge clk);
      lat_chk = 1;
      send(32'h0000_0005, 32'h0000_0007, 0, 5'd9, 64'd35);
      drain();
      lat_chk = 0;
`endif

      check("final_queue_empty", 64'(q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wallace_mul_pipe.md
Name: wallace_mul_pipe

Overview:
- Parametrised, pipelined multiplier functional unit for the Tomasulo datapath.
- Wraps a Wallace carry-save reduction tree plus a final carry-propagate add.
- Accepts one issued op per cycle from the multiply reservation station, carrying a ROB/RS tag.
- Returns a tagged 2*WIDTH-bit product to the CDB arbiter through a valid/ready handshake with full backpressure.
- Successor to the fixed 32-bit combinational Wallace multiplier. Adds width/depth generality, signed mode, and pipelining.

Parameters:
- WIDTH, 32, operand width in bits (>=4).
- STAGES, 3, pipeline depth, >=2. Stage 1 registers the CSA sum/carry rows, the last stage registers the final sum, and middle stages are pure delay.
- TAG_W, 5, tag width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  issue request.
- in_ready  out  1  unit can accept this cycle.
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- in_tag  in  TAG_W  destination tag.
- out_valid  out  1  result present.
- out_ready  in  1  CDB grants the result.
- out_prod  out  2*WIDTH  full product.
- out_tag  out  TAG_W  tag of out_prod.
- busy  out  1  any stage holds a valid op.

Behaviour:
- Reset (asynchronous, rst_n low): all per-stage valid bits clear. out_valid=0, busy=0, out_prod=0, out_tag=0. in_ready goes to 1 once reset is released. Reset mid-operation discards all in-flight ops with no result emitted.
- Advance rule: adv = !out_valid || out_ready. On adv, every stage shifts one position and stage 1 loads (in_valid && in_ready). With no adv, all stages hold.
- in_ready = adv. This is combinational from out_valid/out_ready. No combinational path exists from in_valid to out_*.
- Bubbles do not compress: a stalled pipeline holds empty slots. This is accepted for simplicity.
- Handshake: an op is accepted when in_valid && in_ready. A result is consumed when out_valid && out_ready.
- While out_valid=1 && out_ready=0, out_prod and out_tag are stable.
- Latency: exactly STAGES cycles from acceptance to out_valid when no stall occurs. Throughput is 1 op/cycle.
- Arithmetic: each operand is extended to WIDTH+1 bits, sign-extended if in_signed, else zero-extended. The product is taken modulo 2^(2*WIDTH).
  - Partial products are reduced by the Wallace tree to two 2*WIDTH rows, sum and carry. Their sum modulo 2^(2*WIDTH) equals the product.
  - The rows travel through the pipe and are added in the last stage.
- Ordering: results leave in acceptance order. Tags are not checked for uniqueness.
- Simultaneous events: consume and accept in the same cycle is legal and keeps the pipe full. With STAGES=2 the unit sustains back-to-back operation with out_ready held at 1.
- busy = OR of all stage valid bits.

Optional Feature:
- Macro: WALLACE_MUL_FLUSH_EN.
- When defined, the unit adds port flush (in, 1; branch-mispredict squash).
  - On flush=1 at a clock edge, all stage valid bits clear. The cycle after, out_valid=0.
  - An op presented at in_* in the same cycle as flush is not accepted: in_ready is forced to 0 while flush=1.
  - Flush has priority over advance.
- When undefined, there is no flush port, and in_ready follows the Advance rule only.

Decomposition:
- Shared package mul_pkg holds:
  - the stage-payload struct (valid, signed, tag, sum row, carry row);
  - the localparam PROD_W = 2*WIDTH;
  - the localparam for the partial-product count (WIDTH+1).
- One natural sub-module, wallace_csa_tree. It is combinational: WIDTH+1 extended operands in, 2*WIDTH sum and carry rows out. It is built from 3:2 compressor rows generated per level and is reusable by the future MAC unit.
- The top module holds the stage registers, advance/flush control, and the final adder.

Test Plan:
- Unsigned, WIDTH=32, out_ready=1: a=32'h00e00003, b=32'h0000a000, tag=3 -> after 3 cycles out_prod=64'h0000_008C_0001_E000, out_tag=3.
- Unsigned 32'h0000FFFF*32'h0000FFFF issued back-to-back after the previous op -> results arrive on consecutive cycles, second = 64'h0000_0000_FFFE_0001.
- Signed vs unsigned operands 32'hFFFFFFFF*32'h00000002:
  - signed=1 -> 64'hFFFF_FFFF_FFFF_FFFE;
  - signed=0 -> 64'h0000_0001_FFFF_FFFE;
  - signed=1 with 32'h80000000*32'h80000000 -> 64'h4000_0000_0000_0000.
- Backpressure: issue 4 ops, hold out_ready=0 for 5 cycles:
  - in_ready drops when out_valid rises;
  - out_prod/out_tag stay stable;
  - after release, 4 results appear in order with tags intact.
- Reset mid-operation: issue 2 ops, pulse rst_n low asynchronously between edges -> out_valid=0 and busy=0 immediately, no stale result after release.
- With WALLACE_MUL_FLUSH_EN: fill the pipe, assert flush together with a new in_valid -> next cycle out_valid=0 and busy=0, the new op is not accepted, and a subsequent op completes normally in STAGES cycles.
